// File: rtl/sb_arbiter_if.sv
// sb_arbiter_if: handshake and bus signals of the shared s_b evaluator arbiter.
//   NREQ requesters offer 11-bit z operands with tags (req_*). The arbiter
//   drives the external combinational evaluator (sb_z -> sb_s_b). It returns
//   one registered result at a time to a single consumer (rsp_*).
// Modports:
//   master : the environment (requesters, evaluator, result consumer)
//   slave  : the arbiter itself
interface sb_arbiter_if #(
  parameter int NREQ = 4,
  parameter int TAGW = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*11-1:0]   req_z;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [10:0]          sb_z;
  logic [10:0]          sb_s_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2:0]           rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic [10:0]          rsp_s_b;

  modport master (
    output req_valid, req_z, req_tag, sb_s_b, rsp_ready,
    input  req_ready, sb_z, rsp_valid, rsp_id, rsp_tag, rsp_s_b
  );

  modport slave (
    input  req_valid, req_z, req_tag, sb_s_b, rsp_ready,
    output req_ready, sb_z, rsp_valid, rsp_id, rsp_tag, rsp_s_b
  );
endinterface

// File: rtl/sb_arbiter.sv
// sb_arbiter: round-robin arbiter that lets NREQ requesters share one
// external combinational s_b evaluator through a two-stage pipeline.
//   Stage 1 holds the granted operand and drives it to the evaluator.
//   Stage 2 captures the evaluator result and presents it to the consumer.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : sb_arbiter_if.slave (req_*, sb_*, rsp_* handshakes)
//   stat_grants : accepted-request count (saturating at 16'hFFFF)
// Configuration:
//   SB_ARBITER_STATS_EN : when defined, builds the grant counter behind
//                         stat_grants; otherwise stat_grants is tied to 0.
module sb_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sb_arbiter_if.slave     bus,
  output logic [15:0]     stat_grants
);

  // Pipeline occupancy: bit 0 is v1 (operand stage), bit 1 is v2 (result stage).
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    S1    = 2'b01,
    S2    = 2'b10,
    S1S2  = 2'b11
  } state_t;

  state_t          state_r;
  logic            v1_s;
  logic            v2_s;
  logic            v1_next_s;
  logic            v2_next_s;

  logic [2:0]      ptr_r;
  logic [10:0]     z1_r;
  logic [TAGW-1:0] tag1_r;
  logic [2:0]      id1_r;
  logic [10:0]     sb2_r;
  logic [TAGW-1:0] tag2_r;
  logic [2:0]      id2_r;

  // Requester views padded to 8 entries so a 3-bit index is always legal.
  logic [7:0]      valid_ext_s;
  logic [10:0]     z_arr_s   [8];
  logic [TAGW-1:0] tag_arr_s [8];

  logic [3:0]      cand_s;
  logic            found_s;
  logic [2:0]      grant_idx_s;
  logic            adv_s;
  logic            accept_s;
  logic [7:0]      grant_oh_s;
  logic [3:0]      ptr_inc_s;
  logic [2:0]      ptr_next_s;

  assign v1_s = state_r[0];
  assign v2_s = state_r[1];

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_unpack
      if (g < NREQ) begin : g_live
        assign valid_ext_s[g] = bus.req_valid[g];
        assign z_arr_s[g]     = bus.req_z[11*g +: 11];
        assign tag_arr_s[g]   = bus.req_tag[TAGW*g +: TAGW];
      end else begin : g_pad
        assign valid_ext_s[g] = 1'b0;
        assign z_arr_s[g]     = 11'h000;
        assign tag_arr_s[g]   = '0;
      end
    end
  endgenerate

  // Round-robin search: first valid requester at ptr, ptr+1, ... modulo NREQ.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = 3'd0;
    cand_s      = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s      = {1'b0, ptr_r} + 4'(k);
      cand_s      = (cand_s >= 4'(NREQ)) ? (cand_s - 4'(NREQ)) : cand_s;
      grant_idx_s = (!found_s && valid_ext_s[cand_s[2:0]]) ? cand_s[2:0] : grant_idx_s;
      found_s     = found_s | valid_ext_s[cand_s[2:0]];
    end
  end

  // Handshake decisions and next occupancy. Acceptance is gated by rst_n so
  // req_ready stays low while reset is held.
  always_comb begin
    adv_s      = v1_s & (~v2_s | bus.rsp_ready);
    accept_s   = rst_n & found_s & (~v1_s | adv_s);
    grant_oh_s = accept_s ? (8'b0000_0001 << grant_idx_s) : 8'b0000_0000;
    ptr_inc_s  = {1'b0, grant_idx_s} + 4'd1;
    ptr_next_s = (ptr_inc_s == 4'(NREQ)) ? 3'd0 : ptr_inc_s[2:0];
    v1_next_s  = accept_s | (v1_s & ~adv_s);
    v2_next_s  = adv_s | (v2_s & ~bus.rsp_ready);
  end

  assign bus.req_ready = grant_oh_s[NREQ-1:0];
  assign bus.sb_z      = z1_r;
  assign bus.rsp_valid = v2_s;
  assign bus.rsp_id    = id2_r;
  assign bus.rsp_tag   = tag2_r;
  assign bus.rsp_s_b   = sb2_r;

  // Pipeline state, round-robin pointer and both data stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      ptr_r   <= 3'd0;
      z1_r    <= 11'h000;
      tag1_r  <= '0;
      id1_r   <= 3'd0;
      sb2_r   <= 11'h000;
      tag2_r  <= '0;
      id2_r   <= 3'd0;
    end else begin
      state_r <= state_t'({v2_next_s, v1_next_s});
      if (accept_s) begin
        ptr_r  <= ptr_next_s;
        z1_r   <= z_arr_s[grant_idx_s];
        tag1_r <= tag_arr_s[grant_idx_s];
        id1_r  <= grant_idx_s;
      end else if (adv_s) begin
        // Stage 1 empties: clear the operand so sb_z reads 0 while idle.
        z1_r   <= 11'h000;
      end
      if (adv_s) begin
        sb2_r  <= bus.sb_s_b;
        tag2_r <= tag1_r;
        id2_r  <= id1_r;
      end
    end
  end

`ifdef SB_ARBITER_STATS_EN
  logic [15:0] grant_cnt_r;

  // Saturating count of accepted requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_r <= 16'h0000;
    end else if (accept_s && (grant_cnt_r != 16'hFFFF)) begin
      grant_cnt_r <= grant_cnt_r + 16'h0001;
    end
  end

  assign stat_grants = grant_cnt_r;
`else
  assign stat_grants = 16'h0000;
`endif

endmodule

// File: tb/tb_sb_arbiter.sv
// tb_sb_arbiter: table-driven check of sb_arbiter with NREQ=4, TAGW=4.
// Each table row gives one cycle of inputs and the outputs expected in that
// cycle; the evaluator is a bench-side function of sb_z.
module tb_sb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] stat_grants;

  sb_arbiter_if #(.NREQ(4), .TAGW(4)) bus ();

  sb_arbiter #(.NREQ(4), .TAGW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .stat_grants (stat_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] sb_model(input logic [10:0] z);
    return (z ^ {z[4:0], z[10:5]}) + 11'd37;
  endfunction

  assign bus.sb_s_b = sb_model(bus.sb_z);

  logic [10:0] zt   [4] = '{11'h3F0, 11'h0A5, 11'h7FF, 11'h001};
  logic [3:0]  tagt [4] = '{4'd5, 4'd9, 4'd12, 4'd3};

  typedef struct {
    logic       rstn;
    logic [3:0] rv;
    logic       rr;
    logic [3:0] ready;
    logic       rspv;
    logic [1:0] id;
    logic       sbzv;
    logic [1:0] sbzi;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   row_i  = 0;
  int   exp_cnt = 0;

  task automatic add(input logic rstn, input logic [3:0] rv, input logic rr,
                     input logic [3:0] ready, input logic rspv, input logic [1:0] id,
                     input logic sbzv, input logic [1:0] sbzi);
    tbl.push_back('{rstn, rv, rr, ready, rspv, id, sbzv, sbzi});
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row_i, act, exp);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    bus.req_z     = {zt[3], zt[2], zt[1], zt[0]};
    bus.req_tag   = {tagt[3], tagt[2], tagt[1], tagt[0]};

    // rstn rv rr | ready rspv id sbzv sbzi
    // single request, latency 2, reset gating of req_ready
    add(1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
    add(1'b1, 4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 2'd0);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd0);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 2'd0);
    // all four requesting for 8 cycles, full throughput
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
    add(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 2'd0);
    add(1'b1, 4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b1, 2'd0);
    add(1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 1'b1, 2'd1);
    add(1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b1, 2'd2);
    add(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b1, 2'd3);
    add(1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd3, 1'b1, 2'd0);
    add(1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 1'b1, 2'd1);
    add(1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b1, 2'd2);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 2'd3);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b0, 2'd0);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
    // backpressure: two accepted, then stall with held response, then drain
    add(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0, 2'd0);
    add(1'b1, 4'b1110, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b1, 2'd0);
    add(1'b1, 4'b1100, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 2'd1);
    add(1'b1, 4'b1100, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 2'd1);
    add(1'b1, 4'b1100, 1'b1, 4'b0100, 1'b1, 2'd0, 1'b1, 2'd1);
    add(1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b1, 2'd2);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 2'd3);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b0, 2'd0);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
    // pointer wrap: ptr=3 with only requester 1 valid, then ptr must be 2
    add(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0, 2'd0);
    add(1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b1, 2'd2);
    add(1'b1, 4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 2'd1);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, 2'd2);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0, 2'd0);
    // both stages full, reset mid-flight, no stale response afterwards
    add(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0, 2'd0);
    add(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b1, 2'd0);
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 2'd1);
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
    add(1'b1, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b0, 2'd0);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd3);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b0, 2'd0);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      row_i         = i;
      rst_n         = tbl[i].rstn;
      bus.req_valid = tbl[i].rv;
      bus.rsp_ready = tbl[i].rr;
      if (!tbl[i].rstn) exp_cnt = 0;
      @(negedge clk);
      check("req_ready", 32'(bus.req_ready), 32'(tbl[i].ready));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(tbl[i].rspv));
      check("sb_z", 32'(bus.sb_z), tbl[i].sbzv ? 32'(zt[tbl[i].sbzi]) : 32'd0);
      if (tbl[i].rspv) begin
        check("rsp_id", 32'(bus.rsp_id), 32'(tbl[i].id));
        check("rsp_tag", 32'(bus.rsp_tag), 32'(tagt[tbl[i].id]));
        check("rsp_s_b", 32'(bus.rsp_s_b), 32'(sb_model(zt[tbl[i].id])));
      end
`ifdef SB_ARBITER_STATS_EN
      check("stat_grants", 32'(stat_grants), 32'(exp_cnt));
`else
      check("stat_grants", 32'(stat_grants), 32'd0);
`endif
      if (tbl[i].ready != 4'b0000) exp_cnt++;
      @(posedge clk);
      #1;
    end

    // Long burst: every cycle accepts after reset.
    row_i         = -1;
    rst_n         = 1'b0;
    bus.req_valid = 4'b0000;
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
`ifdef SB_ARBITER_STATS_EN
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("stat_grants_sat", 32'(stat_grants), 32'h0000FFFF);
`else
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("stat_grants_off", 32'(stat_grants), 32'd0);
`endif
    bus.req_valid = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_arbiter.md
SB_ARBITER -- requirements
Module: sb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning number of requesters sharing one s_b evaluator (2..8).
REQ-002 The block SHALL have parameter TAGW, default 4, meaning width of the per-request tag returned with the result.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, NREQ, meaning per-requester operand valid.
REQ-006 The block SHALL have port req_ready, output, NREQ, meaning per-requester accept strobe; at most one bit set per cycle.
REQ-007 The block SHALL have port req_z, input, NREQ*11, meaning packed 11-bit z operands, requester i at bits [11i+10:11i].
REQ-008 The block SHALL have port req_tag, input, NREQ*TAGW, meaning packed request tags.
REQ-009 The block SHALL have port sb_z, output, 11, meaning operand driven to the external combinational s_b evaluator.
REQ-010 The block SHALL have port sb_s_b, input, 11, meaning evaluator result for the current sb_z.
REQ-011 The block SHALL have port rsp_valid, output, 1, meaning the result slot is occupied.
REQ-012 The block SHALL have port rsp_ready, input, 1, meaning the consumer takes the result.
REQ-013 The block SHALL have port rsp_id, output, 3, meaning index of the originating requester.
REQ-014 The block SHALL have port rsp_tag, output, TAGW, meaning tag of the originating request.
REQ-015 The block SHALL have port rsp_s_b, output, 11, meaning registered s_b result.
REQ-016 The block SHALL have port stat_grants, output, 16, meaning the accepted-request count.

Function
REQ-017 Pipeline states SHALL be EMPTY, S1 (operand register full), S2 (result register full) and S1S2 (both full), encoded by valid bits v1 and v2.
REQ-018 Acceptance SHALL occur when any req_valid is set and (v1==0 or stage 1 advances in that cycle).
REQ-019 Stage 1 SHALL advance when v1==1 and (v2==0 or rsp_ready==1).
REQ-020 Arbitration SHALL be round-robin from pointer ptr: the first requester with req_valid set, scanning ptr, ptr+1, ... modulo NREQ, is granted.
REQ-021 req_ready SHALL be combinational: the one-hot grant when acceptance occurs, otherwise all zero.
REQ-022 On acceptance, ptr SHALL become (granted index + 1) mod NREQ; otherwise ptr SHALL hold, including while stalled.
REQ-023 On acceptance, the granted z, tag and index SHALL load into stage 1 and v1 SHALL be set.
REQ-024 sb_z SHALL equal the stage-1 z register, and SHALL be 0 when v1==0.
REQ-025 On stage-1 advance, sb_s_b, tag and index SHALL load into the result register and v2 SHALL be set.
REQ-026 rsp_valid SHALL equal v2; the handshake completes when rsp_valid and rsp_ready are both high.
REQ-027 v2 SHALL clear on handshake unless stage 1 advances in the same cycle.
REQ-028 Latency SHALL be 2 cycles: a request accepted in cycle n gives rsp_valid in cycle n+2 when unstalled.
REQ-029 Throughput SHALL be 1 result per cycle with rsp_ready held high.
REQ-030 While rsp_valid==1 and rsp_ready==0, rsp_* outputs SHALL be stable and held.
REQ-031 While rsp_valid==1 and rsp_ready==0, stage 1 SHALL hold its contents.
REQ-032 When both stages are full and rsp_ready==0, no request SHALL be accepted.
REQ-033 A requester that deasserts req_valid before being granted SHALL lose nothing; no request is queued inside the block.
REQ-034 rsp_id SHALL be zero-extended to 3 bits.
REQ-035 The rsp_s_b value SHALL be passed through unmodified from sb_s_b.

Reset
REQ-036 While rst_n is low, v1, v2, ptr, all data registers and stat_grants SHALL be 0, giving rsp_valid=0, req_ready=0 and sb_z=0.
REQ-037 Reset asserted mid-operation SHALL discard in-flight requests without producing a response.
REQ-038 After reset release, the first grant SHALL go to the lowest-index valid requester.

Configuration
REQ-039 With macro SB_ARBITER_STATS_EN defined, stat_grants SHALL increment by 1 on each acceptance and saturate at 16'hFFFF.
REQ-040 With SB_ARBITER_STATS_EN undefined, stat_grants SHALL be constant 0, no counter SHALL be synthesized, and all other behaviour SHALL be identical.

Verification
REQ-041 Bench scenario: reset, then req_valid=4'b0001 with z=11'h3F0 and tag 5, rsp_ready=1 -> rsp_valid in cycle n+2 with rsp_id=0, rsp_tag=5, and rsp_s_b equal to the model s_b(11'h3F0).
REQ-042 Bench scenario: req_valid=4'b1111 held for 8 cycles with rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3 and 8 responses on consecutive cycles.
REQ-043 Bench scenario: rsp_ready=0 while 4 requests are pending -> exactly 2 accepted, then req_ready=0 and rsp_* held; rsp_ready=1 -> remaining requests drain in order with no loss or duplication.
REQ-044 Bench scenario: ptr=3 with only requester 1 valid -> requester 1 granted and ptr becomes 2.
REQ-045 Bench scenario: rst_n pulsed low with v1=v2=1 -> rsp_valid=0 immediately, and no stale response appears after release.
REQ-046 Bench scenario: with SB_ARBITER_STATS_EN defined, 70000 acceptances -> stat_grants=16'hFFFF; with the macro undefined -> stat_grants=0 throughout.
